// File: rtl/inta_sequencer.sv
// CPU-side 8259A interrupt-acknowledge sequencer. It issues the two-pulse INTA_n
// cycle, captures the vector on the second pulse and hands it to the core via valid/ready.
module inta_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       int_req_i,
  input  logic       ie_i,
  input  logic [7:0] data_in_i,
  output logic       inta_n_o,
  output logic [7:0] vec_o,
  output logic       vec_valid_o,
  input  logic       vec_ready_i,
  output logic       busy_o
);

  localparam int MaxCycles = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW = $clog2(MaxCycles) + 1;
  localparam logic [CW-1:0] LowLoad = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GapLoad = CW'(INTA_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD,
    RECOVER
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sync_q;
  logic          inta_n_q;
  logic [7:0]    vec_q;
  logic          vec_valid_q;
  logic          busy_q;
  logic          int_sync;

  assign int_sync = sync_q[1];

  // INT is asynchronous to clk, so it is double-flopped before the FSM looks at it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], int_req_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inta_n_q    <= 1'b1;
      vec_q       <= 8'h00;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (int_sync && ie_i) begin
            state_q  <= ACK1;
            cnt_q    <= LowLoad;
            inta_n_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ACK1: begin
          if (cnt_q == '0) begin
            state_q  <= GAP;
            cnt_q    <= GapLoad;
            inta_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q  <= ACK2;
            cnt_q    <= LowLoad;
            inta_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ACK2: begin
          // The PIC's vector is valid at the end of the second pulse, so sample it here.
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            vec_q       <= data_in_i;
            vec_valid_q <= 1'b1;
            inta_n_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (vec_ready_i) begin
            state_q     <= RECOVER;
            cnt_q       <= GapLoad;
            vec_valid_q <= 1'b0;
          end
        end
        RECOVER: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          inta_n_q    <= 1'b1;
          vec_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign inta_n_o    = inta_n_q;
  assign vec_o       = vec_q;
  assign vec_valid_o = vec_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: checks pulse timing, vector capture,
// backpressure, atomicity of the sequence and asynchronous reset with the clock stopped.
module tb_inta_sequencer;

   logic       clk;
   logic       rst_n;
   logic       intReq;
   logic       ie;
   logic [7:0] dataIn;
   logic       intaN;
   logic [7:0] vec;
   logic       vecValid;
   logic       vecReady;
   logic       busy;
   logic       clkEn;
   int         checks;
   int         failures;

   inta_sequencer #(
      .INTA_LOW_CYCLES(2),
      .INTA_GAP_CYCLES(2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .int_req_i  (intReq),
      .ie_i       (ie),
      .data_in_i  (dataIn),
      .inta_n_o   (intaN),
      .vec_o      (vec),
      .vec_valid_o(vecValid),
      .vec_ready_i(vecReady),
      .busy_o     (busy)
   );

   // The clock can be frozen low so reset can be shown to act without any edge.
   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clkEn) clk = ~clk;
      end
   end

   // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives every core/PIC-side input in one call.
   task automatic applyStimulus(input logic ieV, input logic reqV, input logic readyV,
                                input logic [7:0] dataV);
      ie       = ieV;
      intReq   = reqV;
      vecReady = readyV;
      dataIn   = dataV;
   endtask

   // One comparison: counts it, and on mismatch counts a failure and reports it.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clkEn    = 1'b1;
      rst_n    = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

      // Reset state.
      step();
      step();
      checkOutput("rst_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("rst_vec", vec, 8'h00);
      checkOutput("rst_vec_valid", {7'd0, vecValid}, 8'h00);
      checkOutput("rst_busy", {7'd0, busy}, 8'h00);
      rst_n = 1'b1;
      step();

      // Basic acknowledge with the core ready: edges are numbered from 0 after INT rises.
      $display("[TB] basic acknowledge cycle");
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
      step();                                   // edge 0
      step();                                   // edge 1
      checkOutput("b_e1_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("b_e1_busy", {7'd0, busy}, 8'h00);
      step();                                   // edge 2
      checkOutput("b_e2_inta_n", {7'd0, intaN}, 8'h00);
      checkOutput("b_e2_busy", {7'd0, busy}, 8'h01);
      step();                                   // edge 3
      checkOutput("b_e3_inta_n", {7'd0, intaN}, 8'h00);
      step();                                   // edge 4
      checkOutput("b_e4_inta_n", {7'd0, intaN}, 8'h01);
      step();                                   // edge 5
      checkOutput("b_e5_inta_n", {7'd0, intaN}, 8'h01);
      dataIn = 8'h48;
      step();                                   // edge 6
      checkOutput("b_e6_inta_n", {7'd0, intaN}, 8'h00);
      checkOutput("b_e6_vec_valid", {7'd0, vecValid}, 8'h00);
      step();                                   // edge 7
      checkOutput("b_e7_inta_n", {7'd0, intaN}, 8'h00);
      step();                                   // edge 8
      checkOutput("b_e8_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("b_e8_vec_valid", {7'd0, vecValid}, 8'h01);
      checkOutput("b_e8_vec", vec, 8'h48);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      step();                                   // edge 9
      checkOutput("b_e9_vec_valid", {7'd0, vecValid}, 8'h00);
      checkOutput("b_e9_vec", vec, 8'h48);
      step();                                   // edge 10
      checkOutput("b_e10_busy", {7'd0, busy}, 8'h01);
      step();                                   // edge 11
      checkOutput("b_e11_busy", {7'd0, busy}, 8'h00);
      step();
      checkOutput("b_e12_inta_n", {7'd0, intaN}, 8'h01);

      // Interrupts disabled: INT held high must not start a cycle.
      $display("[TB] interrupts disabled");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < 20; i++) begin
         step();
         checkOutput("dis_inta_n", {7'd0, intaN}, 8'h01);
         checkOutput("dis_busy", {7'd0, busy}, 8'h00);
      end
      // Enabling with int_sync already high starts ACK1 on the very next edge.
      ie = 1'b1;
      step();                                   // ACK1 entry (A2)
      checkOutput("en_inta_n", {7'd0, intaN}, 8'h00);
      step();                                   // A3
      checkOutput("en_a3_inta_n", {7'd0, intaN}, 8'h00);
      step();                                   // A4
      checkOutput("en_a4_inta_n", {7'd0, intaN}, 8'h01);
      step();                                   // A5
      dataIn = 8'h11;
      step();                                   // A6
      checkOutput("en_a6_inta_n", {7'd0, intaN}, 8'h00);
      dataIn = 8'h20;
      step();                                   // A7
      dataIn = 8'h20;
      step();                                   // A8
      checkOutput("dat_vec", vec, 8'h20);
      checkOutput("dat_vec_valid", {7'd0, vecValid}, 8'h01);

      // Backpressure: vec must hold and no new INTA cycle may start.
      $display("[TB] backpressure");
      for (int i = 0; i < 5; i++) begin
         dataIn = (i % 2 == 0) ? 8'h5A : 8'hA5;
         step();
         checkOutput("bp_vec", vec, 8'h20);
         checkOutput("bp_vec_valid", {7'd0, vecValid}, 8'h01);
         checkOutput("bp_inta_n", {7'd0, intaN}, 8'h01);
         checkOutput("bp_busy", {7'd0, busy}, 8'h01);
      end
      vecReady = 1'b1;
      step();                                   // handoff
      checkOutput("bp_hand_valid", {7'd0, vecValid}, 8'h00);
      vecReady = 1'b0;
      step();
      checkOutput("bp_rec1_inta_n", {7'd0, intaN}, 8'h01);
      step();
      checkOutput("bp_rec2_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("bp_rec2_busy", {7'd0, busy}, 8'h00);
      step();                                   // new ACK1 (F2)
      checkOutput("bp_next_inta_n", {7'd0, intaN}, 8'h00);
      checkOutput("bp_next_busy", {7'd0, busy}, 8'h01);

      // Dropping INT and ie during GAP must not abort the sequence.
      $display("[TB] atomic sequence");
      step();                                   // F3
      step();                                   // F4
      checkOutput("at_f4_inta_n", {7'd0, intaN}, 8'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C);
      step();                                   // F5
      step();                                   // F6
      checkOutput("at_f6_inta_n", {7'd0, intaN}, 8'h00);
      step();                                   // F7
      step();                                   // F8
      checkOutput("at_f8_vec", vec, 8'h3C);
      checkOutput("at_f8_vec_valid", {7'd0, vecValid}, 8'h01);
      step();                                   // F9
      checkOutput("at_f9_vec_valid", {7'd0, vecValid}, 8'h00);
      step();
      step();                                   // F11
      checkOutput("at_f11_busy", {7'd0, busy}, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("at_idle_inta_n", {7'd0, intaN}, 8'h01);
         checkOutput("at_idle_busy", {7'd0, busy}, 8'h00);
      end

      // Asynchronous reset mid-ACK2 with the clock frozen.
      $display("[TB] async reset mid-sequence");
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
      for (int i = 0; i < 7; i++) step();       // edges 0..6
      checkOutput("ar_ack2_inta_n", {7'd0, intaN}, 8'h00);
      @(negedge clk);
      #1;
      clkEn = 1'b0;
      #10;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("ar_vec_valid", {7'd0, vecValid}, 8'h00);
      checkOutput("ar_busy", {7'd0, busy}, 8'h00);
      checkOutput("ar_vec", vec, 8'h00);
      #20;
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      rst_n = 1'b1;
      #2;
      clkEn = 1'b1;
      step();
      step();
      checkOutput("ar_post_inta_n", {7'd0, intaN}, 8'h01);
      checkOutput("ar_post_busy", {7'd0, busy}, 8'h00);
      // Synchroniser was cleared, so a fresh INT takes the full two-flop latency.
      intReq = 1'b1;
      step();                                   // edge 0
      step();                                   // edge 1
      checkOutput("ar_sync_e1_inta_n", {7'd0, intaN}, 8'h01);
      step();                                   // edge 2
      checkOutput("ar_sync_e2_inta_n", {7'd0, intaN}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
